fp_add_normalize: RTL and testbench

//  Consumer stage of the single-precision adder, placed after the pre-adder in the datapath.

---
 rtl/fp_add_normalize.sv | 172 +++++++++++++++++
 tb/tb_fp_add_normalize.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_normalize.sv
// Single-precision adder back end: mantissa add/subtract, iterative normalization,
// round-to-nearest-even and binary32 packing, with valid/ready on both sides.
module fp_add_normalize #(
    parameter int unsigned NORM_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign,
    input  logic [7:0]  exp,
    input  logic [27:0] mantis_great,
    input  logic [27:0] mantis_small,
    input  logic        eff_sub,
    input  logic [31:0] special_result,
    input  logic        special_case,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow
);

    typedef enum logic [2:0] {StIdle, StAdd, StNorm, StRound, StDone} state_e;

    state_e      state_q, state_d;
    logic [27:0] sum_q, sum_d;
    logic [27:0] small_q, small_d;
    logic [7:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic        sub_q, sub_d;
    logic [31:0] result_q, result_d;
    logic        overflow_q, overflow_d;

    logic [27:0] add_raw;
    logic [2:0]  lz;
    logic        lz_stop;
    logic [7:0]  exp_m1;
    logic [7:0]  shamt;
    logic [27:0] norm_sum;
    logic [7:0]  norm_exp;
    logic        rnd_inc;
    logic [24:0] mant_rnd;

    assign add_raw = sub_q ? (sum_q - small_q) : (sum_q + small_q);

    // Leading zeros at and below the hidden-bit position, capped at NORM_STEP per cycle,
    // then capped again so the exponent never drops below 1.
    always_comb begin
        lz      = 3'd0;
        lz_stop = 1'b0;
        for (int i = 0; i < int'(NORM_STEP); i++) begin
            if (!lz_stop && !sum_q[26-i]) begin
                lz = lz + 3'd1;
            end else begin
                lz_stop = 1'b1;
            end
        end
        exp_m1   = exp_q - 8'd1;
        shamt    = ({5'd0, lz} > exp_m1) ? exp_m1 : {5'd0, lz};
        norm_sum = sum_q << shamt;
        norm_exp = exp_q - shamt;
    end

    assign rnd_inc  = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
    assign mant_rnd = {1'b0, sum_q[26:3]} + {24'd0, rnd_inc};

    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        small_d    = small_q;
        exp_d      = exp_q;
        sign_d     = sign_q;
        sub_d      = sub_q;
        result_d   = result_q;
        overflow_d = overflow_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sum_d      = mantis_great;
                    small_d    = mantis_small;
                    exp_d      = exp;
                    sign_d     = sign;
                    sub_d      = eff_sub;
                    overflow_d = 1'b0;
                    if (special_case) begin
                        result_d = special_result;
                        state_d  = StDone;
                    end else begin
                        state_d  = StAdd;
                    end
                end
            end
            StAdd: begin
                if (add_raw == 28'd0) begin
                    result_d = 32'd0;
                    state_d  = StDone;
                end else if (add_raw[27]) begin
                    // Carry out: shift right once, keeping the dropped bit as sticky.
                    sum_d = {1'b0, add_raw[27:2], add_raw[1] | add_raw[0]};
                    exp_d = exp_q + 8'd1;
                    if (exp_q == 8'd254) begin
                        result_d   = {sign_q, 8'hFF, 23'd0};
                        overflow_d = 1'b1;
                        state_d    = StDone;
                    end else begin
                        state_d    = StRound;
                    end
                end else begin
                    sum_d   = add_raw;
                    state_d = (!add_raw[26] && exp_q > 8'd1) ? StNorm : StRound;
                end
            end
            StNorm: begin
                sum_d = norm_sum;
                exp_d = norm_exp;
                if (norm_sum[26] || norm_exp == 8'd1) begin
                    state_d = StRound;
                end
            end
            StRound: begin
                if (mant_rnd[24]) begin
                    if (exp_q == 8'd254) begin
                        result_d   = {sign_q, 8'hFF, 23'd0};
                        overflow_d = 1'b1;
                    end else begin
                        result_d = {sign_q, exp_q + 8'd1, mant_rnd[23:1]};
                    end
                end else begin
                    // Exponent 1 without a hidden bit packs as a subnormal.
                    result_d = {sign_q, (exp_q == 8'd1 && !mant_rnd[23]) ? 8'd0 : exp_q,
                                mant_rnd[22:0]};
                end
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            sum_q      <= 28'd0;
            small_q    <= 28'd0;
            exp_q      <= 8'd0;
            sign_q     <= 1'b0;
            sub_q      <= 1'b0;
            result_q   <= 32'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            small_q    <= small_d;
            exp_q      <= exp_d;
            sign_q     <= sign_d;
            sub_q      <= sub_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_fp_add_normalize.sv
// Bench for fp_add_normalize: two instances (NORM_STEP 1 and 2) share stimulus; results and
// latencies are compared against an arithmetic reference model plus directed expectations.
module tb_fp_add_normalize;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mantis_great;
    logic [27:0] mantis_small;
    logic        eff_sub;
    logic [31:0] special_result;
    logic        special_case;
    logic        out_ready;

    logic        in_ready1, out_valid1, overflow1;
    logic [31:0] result1;
    logic        in_ready2, out_valid2, overflow2;
    logic [31:0] result2;

    int checks = 0;
    int passed = 0;

    logic [31:0] got_res [2];
    logic        got_ovf [2];
    int          got_lat [2];

    always #5 clk = ~clk;

    fp_add_normalize #(.NORM_STEP(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .sign(sign),
        .exp(exp), .mantis_great(mantis_great), .mantis_small(mantis_small),
        .eff_sub(eff_sub), .special_result(special_result), .special_case(special_case),
        .out_valid(out_valid1), .out_ready(out_ready), .result(result1),
        .overflow(overflow1)
    );

    fp_add_normalize #(.NORM_STEP(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .sign(sign),
        .exp(exp), .mantis_great(mantis_great), .mantis_small(mantis_small),
        .eff_sub(eff_sub), .special_result(special_result), .special_case(special_case),
        .out_valid(out_valid2), .out_ready(out_ready), .result(result2),
        .overflow(overflow2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    endtask

    // Value-level model: exact integer sum, normalize until the hidden bit is set or the
    // exponent bottoms out, then round the 3 extra bits to nearest-even.
    function automatic void ref_model(input logic sg, input logic [7:0] e_in,
                                      input logic [27:0] g, input logic [27:0] sm,
                                      input logic sub, input int step,
                                      output logic [31:0] res, output logic ovf,
                                      output int lat);
        longint m, q;
        int     e, shifts, rem;
        ovf = 1'b0;
        e   = int'(e_in);
        m   = sub ? (longint'(g) - longint'(sm)) : (longint'(g) + longint'(sm));
        if (m == 0) begin
            res = 32'd0; lat = 1; return;
        end
        if (m >= (longint'(1) << 27)) begin
            m = (m >> 1) | (m & 1);
            e++;
            if (e == 255) begin
                res = {sg, 8'hFF, 23'd0}; ovf = 1'b1; lat = 1; return;
            end
        end
        shifts = 0;
        while (m < (longint'(1) << 26) && e > 1) begin
            m = m * 2; e--; shifts++;
        end
        lat = 2 + (shifts + step - 1) / step;
        q   = m >> 3;
        rem = int'(m & 7);
        if (rem > 4 || (rem == 4 && q[0])) q++;
        if (q >= (longint'(1) << 24)) begin
            q = q >> 1; e++;
        end
        if (e >= 255) begin
            res = {sg, 8'hFF, 23'd0}; ovf = 1'b1; return;
        end
        res = {sg, (q < (longint'(1) << 23)) ? 8'd0 : 8'(e), q[22:0]};
    endfunction

    task automatic run_op(input string tag, input logic sg, input logic [7:0] e,
                          input logic [27:0] g, input logic [27:0] sm, input logic sub);
        logic [31:0] m_res [2];
        logic        m_ovf [2];
        int          m_lat [2];
        bit          got [2];
        ref_model(sg, e, g, sm, sub, 1, m_res[0], m_ovf[0], m_lat[0]);
        ref_model(sg, e, g, sm, sub, 2, m_res[1], m_ovf[1], m_lat[1]);
        for (int k = 0; k < 2; k++) begin
            got[k] = 1'b0; got_res[k] = 32'd0; got_ovf[k] = 1'b0; got_lat[k] = -1;
        end
        sign = sg; exp = e; mantis_great = g; mantis_small = sm; eff_sub = sub;
        special_case = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 60 && !(got[0] && got[1]); c++) begin
            if (!got[0] && out_valid1) begin
                got[0] = 1'b1; got_lat[0] = c; got_res[0] = result1; got_ovf[0] = overflow1;
            end
            if (!got[1] && out_valid2) begin
                got[1] = 1'b1; got_lat[1] = c; got_res[1] = result2; got_ovf[1] = overflow2;
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s/step%0d/done", tag, k + 1), 32'(got[k]), 32'd1);
            chk($sformatf("%s/step%0d/result", tag, k + 1), got_res[k], m_res[k]);
            chk($sformatf("%s/step%0d/overflow", tag, k + 1), 32'(got_ovf[k]), 32'(m_ovf[k]));
            chk($sformatf("%s/step%0d/latency", tag, k + 1), got_lat[k], m_lat[k]);
        end
    endtask

    initial begin
        logic [7:0]  r_e;
        logic [27:0] r_g, r_s;
        longint      r_x;

        rst = 1'b1; in_valid = 1'b0; sign = 1'b0; exp = 8'd0; mantis_great = 28'd0;
        mantis_small = 28'd0; eff_sub = 1'b0; special_result = 32'd0; special_case = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/in_ready", 32'(in_ready1), 32'd1);
        chk("reset/out_valid", 32'(out_valid1), 32'd0);
        chk("reset/result", result1, 32'd0);
        chk("reset/overflow", 32'(overflow1), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("one_plus_one", 1'b0, 8'd127, 28'h4000000, 28'h4000000, 1'b0);
        chk("one_plus_one/value", got_res[0], 32'h40000000);
        chk("one_plus_one/lat", got_lat[0], 2);

        run_op("one_minus_3q", 1'b0, 8'd127, 28'h4000000, 28'h3000000, 1'b1);
        chk("one_minus_3q/value", got_res[0], 32'h3E800000);
        chk("one_minus_3q/lat1", got_lat[0], 4);
        chk("one_minus_3q/lat2", got_lat[1], 3);

        run_op("ovf", 1'b1, 8'd254, 28'h7FFFFF8, 28'h7FFFFF8, 1'b0);
        chk("ovf/value", got_res[0], 32'hFF800000);
        chk("ovf/flag", 32'(got_ovf[0]), 32'd1);

        run_op("tie_even", 1'b0, 8'd127, 28'h4000000, 28'h0000004, 1'b0);
        chk("tie_even/value", got_res[0], 32'h3F800000);
        run_op("tie_up", 1'b0, 8'd127, 28'h4000000, 28'h000000C, 1'b0);
        chk("tie_up/value", got_res[0], 32'h3F800002);

        run_op("x_minus_x", 1'b1, 8'd127, 28'h4000000, 28'h4000000, 1'b1);
        chk("x_minus_x/value", got_res[0], 32'h00000000);

        // Special result under backpressure; a busy-time bundle must be ignored.
        out_ready = 1'b0; special_case = 1'b1; special_result = 32'h7FC00000; in_valid = 1'b1;
        @(posedge clk); #1;
        special_result = 32'h12345678;
        chk("special/out_valid", 32'(out_valid1), 32'd1);
        chk("special/result", result1, 32'h7FC00000);
        chk("special/in_ready", 32'(in_ready1), 32'd0);
        chk("special/out_valid2", 32'(out_valid2), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("special/hold_valid", 32'(out_valid1), 32'd1);
            chk("special/hold_result", result1, 32'h7FC00000);
            chk("special/hold_busy", 32'(in_ready1), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("handoff/out_valid", 32'(out_valid1), 32'd0);
        chk("handoff/no_accept", 32'(in_ready1), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("next_accept/result", result1, 32'h12345678);
        chk("next_accept/out_valid", 32'(out_valid1), 32'd1);
        @(posedge clk); #1;
        special_case = 1'b0;

        // Reset while normalizing drops the operation.
        sign = 1'b0; exp = 8'd127; mantis_great = 28'h4000000; mantis_small = 28'h3000000;
        eff_sub = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort/in_ready", 32'(in_ready1), 32'd1);
        chk("abort/in_ready2", 32'(in_ready2), 32'd1);
        chk("abort/result", result1, 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("abort/no_valid", 32'({out_valid1, out_valid2}), 32'd0);
            @(posedge clk); #1;
        end

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) r_e = ($urandom_range(0, 1) == 0) ? 8'd1 : 8'd254;
            else r_e = 8'($urandom_range(1, 254));
            if (r_e > 8'd1) r_g = {2'b01, 26'($urandom)};
            else r_g = {1'b0, 27'($urandom)};
            case ($urandom_range(0, 3))
                0: r_s = 28'(longint'($urandom) % (longint'(r_g) + 1));
                1: begin
                    r_x = longint'($urandom_range(0, 4095));
                    r_s = (r_x > longint'(r_g)) ? 28'd0 : 28'(longint'(r_g) - r_x);
                end
                2: r_s = r_g >> $urandom_range(0, 27);
                default: r_s = r_g;
            endcase
            run_op($sformatf("rand%0d", n), 1'($urandom), r_e, r_g, r_s, 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
